// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces scanner presses, builds a BCD entry
// buffer from digit/backspace/clear keys, and hands off committed entries
// through a valid/ack pair.
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS     = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_ready,
  input  logic [4:0]  key_value,
  input  logic        out_ack,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic [15:0] entry_data,
  output logic        entry_valid,
  output logic        key_pulse,
  output logic        overflow_err
);

  // Nibbles above MAX_DIGITS are forced to zero on every digit shift-in.
  localparam logic [31:0] MASK32   = (32'h1 << (4 * MAX_DIGITS)) - 32'h1;
  localparam logic [15:0] DIG_MASK = MASK32[15:0];

  typedef enum logic [1:0] {ST_ARMED, ST_HELD, ST_OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync_p0;
  logic        r_sync_p1;
  logic        r_sync_prev;
  logic [1:0]  r_prime;
  logic [7:0]  r_rel_cnt;
  logic [7:0]  w_rel_nxt;
  logic [15:0] r_digits;
  logic [15:0] w_digits_nxt;
  logic [2:0]  r_digit_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] r_entry;
  logic [15:0] w_entry_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_pulse;
  logic        w_pulse_nxt;
  logic        r_ovf;
  logic        w_ovf_nxt;
  logic        w_press;

  // Two-flop synchronizer plus edge history. The history flop resets high and
  // only starts following the synchronizer once the chain holds real samples,
  // so a key still held across reset release is never seen as a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0   <= 1'b0;
      r_sync_p1   <= 1'b0;
      r_sync_prev <= 1'b1;
      r_prime     <= 2'b00;
    end else begin
      r_sync_p0   <= key_ready;
      r_sync_p1   <= r_sync_p0;
      r_prime     <= {r_prime[0], 1'b1};
      if (r_prime[1]) begin
        r_sync_prev <= r_sync_p1;
      end
    end
  end

  assign w_press = r_sync_p1 & ~r_sync_prev;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, key decode and buffer update.
  always_comb begin
    w_state_nxt  = r_state;
    w_rel_nxt    = r_rel_cnt;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_digit_cnt;
    w_entry_nxt  = r_entry;
    w_valid_nxt  = r_valid;
    w_pulse_nxt  = 1'b0;
    w_ovf_nxt    = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_press) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = ST_HELD;
          w_rel_nxt   = 8'd0;
          if (key_value <= 5'd9) begin
            if (r_digit_cnt < 3'(MAX_DIGITS)) begin
              w_digits_nxt = {r_digits[11:0], key_value[3:0]} & DIG_MASK;
              w_cnt_nxt    = r_digit_cnt + 3'd1;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else if (key_value == 5'd10) begin
            if (r_digit_cnt != 3'd0) begin
              w_digits_nxt = {4'h0, r_digits[15:4]};
              w_cnt_nxt    = r_digit_cnt - 3'd1;
            end
          end else if (key_value == 5'd11) begin
            w_digits_nxt = 16'h0000;
            w_cnt_nxt    = 3'd0;
          end else if (key_value == 5'd14) begin
            if (r_digit_cnt != 3'd0) begin
              w_entry_nxt  = r_digits;
              w_valid_nxt  = 1'b1;
              w_digits_nxt = 16'h0000;
              w_cnt_nxt    = 3'd0;
              w_state_nxt  = ST_OUT;
            end
          end
        end
      end
      ST_HELD: begin
        if (r_sync_p1) begin
          w_rel_nxt = 8'd0;
        end else if (r_rel_cnt + 8'd1 == 8'(RELEASE_CYCLES)) begin
          w_rel_nxt   = 8'd0;
          w_state_nxt = ST_ARMED;
        end else begin
          w_rel_nxt = r_rel_cnt + 8'd1;
        end
      end
      ST_OUT: begin
        if (out_ack) begin
          w_valid_nxt = 1'b0;
          w_rel_nxt   = 8'd0;
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_ARMED;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel_cnt   <= 8'd0;
      r_digits    <= 16'h0000;
      r_digit_cnt <= 3'd0;
      r_entry     <= 16'h0000;
      r_valid     <= 1'b0;
      r_pulse     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_rel_cnt   <= w_rel_nxt;
      r_digits    <= w_digits_nxt;
      r_digit_cnt <= w_cnt_nxt;
      r_entry     <= w_entry_nxt;
      r_valid     <= w_valid_nxt;
      r_pulse     <= w_pulse_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign digits       = r_digits;
  assign digit_cnt    = r_digit_cnt;
  assign entry_data   = r_entry;
  assign entry_valid  = r_valid;
  assign key_pulse    = r_pulse;
  assign overflow_err = r_ovf;

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 4: maximum BCD digits held in the entry buffer (1..4).
REQ-002 Parameter RELEASE_CYCLES, default 4: consecutive clk cycles key_ready must be low before the next press is armed (1..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_ready  input  1  scanner key-held flag, slow-clock domain, level.
REQ-006 key_value  input  5  scanner key code, stable while key_ready high.
REQ-007 out_ack  input  1  consumer accepts entry_data while entry_valid high.
REQ-008 digits  output  16  live entry buffer, 4 BCD nibbles, newest digit in [3:0].
REQ-009 digit_cnt  output  3  number of digits in buffer (0..MAX_DIGITS).
REQ-010 entry_data  output  16  committed entry, valid while entry_valid high.
REQ-011 entry_valid  output  1  committed entry pending acknowledge.
REQ-012 key_pulse  output  1  one-cycle pulse per accepted press.
REQ-013 overflow_err  output  1  one-cycle pulse when a digit is rejected because the buffer is full.

Function
REQ-014 key_ready SHALL pass through a 2-flop synchronizer; a press is the rising edge of the synchronized signal.
REQ-015 A key_ready sampled high at edge N SHALL produce a press decision, key_value capture, and register update at edge N+2.
REQ-016 FSM states SHALL be ARMED, HELD and OUT; the reset state is ARMED.
REQ-017 ARMED: on a press, SHALL decode key_value, assert key_pulse for 1 cycle, go to HELD, or to OUT for an accepted enter.
REQ-018 Codes 0-9 are digits: if digit_cnt<MAX_DIGITS, digits <= {digits[11:0],code[3:0]} and digit_cnt+1; else buffer unchanged and overflow_err pulses.
REQ-019 Code 10 (backspace): if digit_cnt>0, digits <= {4'h0,digits[15:4]} and digit_cnt-1; else no change.
REQ-020 Code 11 (clear): digits <= 0 and digit_cnt <= 0.
REQ-021 Code 14 (enter): if digit_cnt>0, entry_data <= digits, entry_valid <= 1, digits/digit_cnt <= 0, and the next state is OUT; if digit_cnt=0, no effect and the next state is HELD.
REQ-022 Codes 12, 13 and 15-31 SHALL be ignored but still pulse key_pulse and go to HELD.
REQ-023 HELD: a release counter SHALL increment each cycle synchronized key_ready is low and clear when it is high; the FSM goes to ARMED when the count reaches RELEASE_CYCLES.
REQ-024 OUT: entry_valid and entry_data SHALL hold until out_ack is sampled high, then entry_valid drops at that edge and the FSM enters HELD with the release counter cleared.
REQ-025 Presses occurring in HELD or OUT SHALL be ignored, with no key_pulse and no buffer change.
REQ-026 out_ack while entry_valid is low SHALL have no effect.
REQ-027 Bits of digits above MAX_DIGITS*4 SHALL always read 0.

Reset
REQ-028 rst high SHALL immediately clear digits, digit_cnt, entry_data, entry_valid, key_pulse, overflow_err, the synchronizer, the release counter, and the FSM (to ARMED).
REQ-029 If key_ready is already high when rst deasserts, it SHALL NOT count as a press; a low-to-high transition is required.
REQ-030 rst asserted while in OUT SHALL discard the pending entry without an acknowledge.

Verification
REQ-031 Press 1,2,3 (each followed by release ≥RELEASE_CYCLES) -> digits=16'h0123, digit_cnt=3, three key_pulse pulses.
REQ-032 Press 1,2,3,4,5 -> after the 5th: digits=16'h1234, digit_cnt=4, overflow_err pulses once.
REQ-033 Enter 4,2, then code 14, out_ack low for 10 cycles, then high -> entry_valid high with entry_data=16'h0042 until the ack edge; digits=0 and digit_cnt=0.
REQ-034 Enter 7,8, then code 10, then code 11 -> 16'h0078, then 16'h0007 (cnt 1), then 0 (cnt 0); code 14 at cnt 0 leaves entry_valid low.
REQ-035 Hold key_ready high 50 cycles with a 2-cycle low glitch (RELEASE_CYCLES=4) -> only one press accepted; a glitch of 4 cycles or more lets the next rising edge be accepted.
REQ-036 Assert rst in OUT with entry_valid high -> all outputs 0 immediately; with key_ready held high across deassertion, no key_pulse until key_ready toggles.
